// File: rtl/meta_info_chip_if.sv
// Host-side bundle for the meta info ROM: packed {proj_idx, chr_idx} request
// and the registered ASCII character returned by the chip.
interface meta_info_chip_if;
    logic [11:0] io_in;
    logic [7:0]  io_out;

    // Host drives the lookup index and reads the character back.
    modport master (
        output io_in,
        input  io_out
    );

    // The chip consumes the index and presents the character.
    modport slave (
        input  io_in,
        output io_out
    );
endinterface

// File: rtl/meta_info_chip.sv
// Read-only meta info character ROM: io_out is the registered character chr_idx of project proj_idx's string.
// Optional build macro META_CHECKSUM_EN: chr_idx 63 returns the XOR of the string's non-NUL characters.
module meta_info_chip (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] io_in,
    output logic [7:0]  io_out
);

    logic [5:0] w_proj;
    logic [5:0] w_chr;
    logic [7:0] w_char;
    logic [7:0] r_out;

    assign w_proj = io_in[11:6];
    assign w_chr  = io_in[5:0];
    assign io_out = r_out;

    // Character of the string table; anything past the end of a string is NUL.
    function automatic logic [7:0] rom_char(input logic [5:0] proj, input logic [5:0] chr);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = proj / 6'd10;
        ones = proj % 6'd10;
        rom_char = 8'h00;
        if (proj == 6'd0) begin
            case (chr)
                6'd0:    rom_char = 8'h31;
                6'd1:    rom_char = 8'h38;
                6'd2:    rom_char = 8'h2D;
                6'd3:    rom_char = 8'h32;
                6'd4:    rom_char = 8'h32;
                6'd5:    rom_char = 8'h34;
                6'd6:    rom_char = 8'h20;
                6'd7:    rom_char = 8'h53;
                6'd8:    rom_char = 8'h32;
                6'd9:    rom_char = 8'h33;
                6'd10:   rom_char = 8'h20;
                6'd11:   rom_char = 8'h54;
                6'd12:   rom_char = 8'h61;
                6'd13:   rom_char = 8'h70;
                6'd14:   rom_char = 8'h65;
                6'd15:   rom_char = 8'h6F;
                6'd16:   rom_char = 8'h75;
                6'd17:   rom_char = 8'h74;
                default: rom_char = 8'h00;
            endcase
        end else begin
            case (chr)
                6'd0:    rom_char = 8'h44;
                6'd1:    rom_char = 8'h65;
                6'd2:    rom_char = 8'h73;
                6'd3:    rom_char = 8'h69;
                6'd4:    rom_char = 8'h67;
                6'd5:    rom_char = 8'h6E;
                6'd6:    rom_char = 8'h20;
                6'd7:    rom_char = 8'h30 + {2'b00, tens};
                6'd8:    rom_char = 8'h30 + {2'b00, ones};
                default: rom_char = 8'h00;
            endcase
        end
    endfunction

`ifdef META_CHECKSUM_EN
    // "Design " folds to 0x12; the two digit characters' 0x30 offsets cancel.
    function automatic logic [7:0] string_xor(input logic [5:0] proj);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = proj / 6'd10;
        ones = proj % 6'd10;
        if (proj == 6'd0) begin
            string_xor = 8'h0C;
        end else begin
            string_xor = 8'h12 ^ {2'b00, tens} ^ {2'b00, ones};
        end
    endfunction
`endif

    // Next character selected from the current request.
    always_comb begin
        w_char = 8'h00;
`ifdef META_CHECKSUM_EN
        if (w_chr == 6'd63) begin
            w_char = string_xor(w_proj);
        end else begin
            w_char = rom_char(w_proj, w_chr);
        end
`else
        w_char = rom_char(w_proj, w_chr);
`endif
    end

    // Output register with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out <= 8'h00;
        end else begin
            r_out <= w_char;
        end
    end

endmodule

// File: tb/tb_meta_info_chip.sv
// Directed self-checking bench for meta_info_chip: reset, full string dump,
// digit boundaries, past-end indices, back-to-back changes and index 63.
module tb_meta_info_chip;

    logic clock;
    logic reset;
    int   n_assert;
    int   n_fail;

    meta_info_chip_if bif ();

    meta_info_chip dut (
        .clock  (clock),
        .reset  (reset),
        .io_in  (bif.io_in),
        .io_out (bif.io_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic apply(input logic [5:0] p, input logic [5:0] c, input int edges);
        @(negedge clock);
        bif.io_in = {p, c};
        repeat (edges) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        n_assert++;
        assert (bif.io_out === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, bif.io_out, exp);
        end
    endtask

    initial begin
        string s;
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bif.io_in = {6'd5, 6'd0};

        // Reset then release
        repeat (2) @(posedge clock);
        #1;
        check("reset_zero", 8'h00);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("after_reset_D", 8'h44);

        // Full string dump, each index held two edges, through the terminator
        for (int p = 0; p < 64; p++) begin
            if (p == 0) s = "18-224 S23 Tapeout";
            else        s = $sformatf("Design %02d", p);
            for (int c = 0; c <= s.len(); c++) begin
                apply(6'(p), 6'(c), 2);
                if (c == s.len()) check($sformatf("dump_p%0d_nul%0d", p, c), 8'h00);
                else              check($sformatf("dump_p%0d_c%0d", p, c), 8'(s[c]));
            end
        end

        // Digit boundaries
        apply(6'd10, 6'd7, 2); check("d10_tens", 8'h31);
        apply(6'd10, 6'd8, 2); check("d10_ones", 8'h30);
        apply(6'd9,  6'd8, 2); check("d09_ones", 8'h39);
        apply(6'd1,  6'd7, 2); check("d01_tens", 8'h30);
        apply(6'd63, 6'd7, 2); check("d63_tens", 8'h36);

        // Past-end
        apply(6'd5, 6'd9,  2); check("past_5_9",  8'h00);
        apply(6'd5, 6'd40, 2); check("past_5_40", 8'h00);
        apply(6'd0, 6'd18, 2); check("past_0_18", 8'h00);
        apply(6'd0, 6'd62, 2); check("past_0_62", 8'h00);

        // Back-to-back changes, one edge latency
        apply(6'd0, 6'd0, 1); check("b2b_0_0", 8'h31);
        apply(6'd1, 6'd0, 1); check("b2b_1_0", 8'h44);
        apply(6'd0, 6'd1, 1); check("b2b_0_1", 8'h38);

        // Reset mid-operation, no recovery cycles
        apply(6'd10, 6'd7, 1); check("pre_mid_reset", 8'h31);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_reset", 8'h00);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_mid_reset", 8'h31);

        // Index 63
`ifdef META_CHECKSUM_EN
        apply(6'd5, 6'd63, 2); check("idx63_p5", 8'h17);
        apply(6'd0, 6'd63, 2); check("idx63_p0", 8'h0C);
`else
        apply(6'd5, 6'd63, 2); check("idx63_p5", 8'h00);
        apply(6'd0, 6'd63, 2); check("idx63_p0", 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/meta_info_chip.md
Name: meta_info_chip

Overview:
Read-only "meta info" character ROM for the shuttle. Given a 6-bit project index and a 6-bit character index, it returns one ASCII character of that project's NUL-terminated description string on an 8-bit output. Host logic walks the character index from 0 upward until it reads 0x00. The block sits at the top level as a standalone chip, with packed io_in/io_out buses.

Parameters:
None; the string table is fixed in RTL.

Ports:
clock  input  1  single system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
io_in  input  12  {proj_idx[11:6], chr_idx[5:0]}
io_out  output  8  ASCII character of proj_idx's string at chr_idx; 0x00 = terminator / past end

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - While reset is sampled high at a rising edge, io_out <= 0x00.
  - No other state exists.
- Latency: io_out is a register.
  - At each rising edge with reset low, io_out <= ROM[proj_idx][chr_idx] using io_in sampled at that edge.
  - Result is valid after the first rising edge following an io_in change. It is stable for any host sampling two edges after the change.
  - No handshake; io_in may change every cycle.
- String table (ASCII, each string followed by implicit 0x00):
  - proj_idx 0: "18-224 S23 Tapeout" (18 chars, indices 0..17).
  - proj_idx 1..63: "Design NN" (9 chars), where NN is the two-digit zero-padded decimal proj_idx.
    - Index 0..6 = 'D','e','s','i','g','n',' '.
    - Index 7 = '0' + proj_idx/10.
    - Index 8 = '0' + proj_idx%10.
- Boundary rules:
  - chr_idx == string length -> 0x00.
  - Any chr_idx greater than the length, up to 62 -> 0x00.
  - chr_idx 63 -> 0x00, unless the optional feature is enabled.
  - Output never contains an undefined/X value for any of the 4096 input combinations.
- Reset mid-operation: the edge with reset high forces 0x00. The first edge with reset low returns the normal lookup. No recovery cycles.
- Implementation freedom: ROM as case statement or computed digits, as long as the mapping above is exact. Purely synchronous, no latches.

Optional Feature:
- Macro: META_CHECKSUM_EN.
- Defined: chr_idx 63 returns the 8-bit XOR of all non-NUL characters of proj_idx's string. Same one-register latency.
- Not defined: chr_idx 63 returns 0x00 like any other past-end index.
- Indices 0..62 are identical in both builds.

Test Plan:
- Reset: hold reset high 2 cycles with io_in = {6'd5, 6'd0} -> io_out = 0x00. Deassert, wait 1 edge -> io_out = 0x44 ('D').
- Full string dump: for each proj_idx 0..63, step chr_idx 0..62, hold each 2 edges, stop at 0x00.
  - proj 0 reads "18-224 S23 Tapeout" with 0x00 at chr 18.
  - proj 7 reads "Design 07" with 0x00 at chr 9.
  - proj 63 reads "Design 63".
- Digit boundaries:
  - {10, 7} -> 0x31 ('1').
  - {10, 8} -> 0x30 ('0').
  - {9, 8} -> 0x39 ('9').
  - {1, 7} -> 0x30 ('0').
- Past-end: {5, 9}, {5, 40}, {0, 18} and {0, 62} -> all 0x00.
- Back-to-back change: change io_in every cycle {0,0} -> {1,0} -> {0,1}; io_out one edge later follows 0x31, 0x44, 0x38 ('8').
- Index 63:
  - Without META_CHECKSUM_EN: {5, 63} -> 0x00.
  - With META_CHECKSUM_EN: {5, 63} -> 0x17, the XOR of "Design 05".
